// File: rtl/affinex_pkg.sv
// Shared types and register map for the tqvp_affinex_pipe affine-transform peripheral.
package affinex_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    MUL   = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_CONTROL = 6'h00;
  localparam logic [5:0] ADDR_STATUS  = 6'h04;
  localparam logic [5:0] ADDR_A       = 6'h08;
  localparam logic [5:0] ADDR_B       = 6'h0C;
  localparam logic [5:0] ADDR_D       = 6'h10;
  localparam logic [5:0] ADDR_E       = 6'h14;
  localparam logic [5:0] ADDR_TX      = 6'h18;
  localparam logic [5:0] ADDR_TY      = 6'h1C;
  localparam logic [5:0] ADDR_XY_IN   = 6'h20;
  localparam logic [5:0] ADDR_XY_OUT  = 6'h24;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLEAR  = 2;

  localparam int ST_OUT_VALID = 0;
  localparam int ST_BUSY      = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_EMPTY     = 3;
  localparam int ST_OVF       = 4;
  localparam int ST_SAT       = 5;

endpackage

// File: rtl/affinex_seq_mul.sv
// Signed radix-2 shift-add multiplier: operands captured on start, done pulses DATA_W cycles later.
module affinex_seq_mul #(
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a_i,
  input  logic [DATA_W-1:0]     b_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  done,
  output logic                  busy
);

  localparam int PW = 2 * DATA_W;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic [PW-1:0]     acc_r;
  logic [PW-1:0]     mcand_r;
  logic [DATA_W-1:0] mplier_r;
  logic [CW-1:0]     bit_r;
  logic              busy_r;
  logic              done_r;

  // Bit 0 is folded into the load so the last (negatively weighted) bit lands DATA_W-1 edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      bit_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (start) begin
        acc_r    <= b_i[0] ? {{DATA_W{a_i[DATA_W-1]}}, a_i} : '0;
        mcand_r  <= {{(DATA_W-1){a_i[DATA_W-1]}}, a_i, 1'b0};
        mplier_r <= {1'b0, b_i[DATA_W-1:1]};
        bit_r    <= CW'(1);
        busy_r   <= 1'b1;
      end else if (busy_r) begin
        if (mplier_r[0]) begin
          acc_r <= (bit_r == LAST_BIT) ? (acc_r - mcand_r) : (acc_r + mcand_r);
        end
        mcand_r  <= mcand_r << 1;
        mplier_r <= mplier_r >> 1;
        bit_r    <= bit_r + CW'(1);
        if (bit_r == LAST_BIT) begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
      end
    end
  end

  assign result_o = acc_r;
  assign done     = done_r;
  assign busy     = busy_r;

endmodule

// File: rtl/tqvp_affinex_pipe.sv
// TinyQV MMIO affine transform: x' = a*x + b*y + tx, y' = d*x + e*y + ty, on one sequential multiplier.
// Define AFFINEX_SAT_EN to clamp results to DATA_W bits and flag STATUS.sat; otherwise results wrap.
module tqvp_affinex_pipe
  import affinex_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FRAC_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [7:0]  uo_out,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int PW    = 2 * DATA_W;
  localparam int AW    = PW + 2;
  localparam int RW    = AW + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [RW-1:0]  HALF      = {{(RW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
`ifdef AFFINEX_SAT_EN
  localparam logic signed [RW-1:0] MAX_V = $signed({{(RW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [RW-1:0] MIN_V = ~MAX_V;
`endif

  function automatic logic [15:0] sext16(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v;
    return 16'(s);
  endfunction

  function automatic logic [31:0] sext32(input logic [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v;
    return 32'(s);
  endfunction

  state_t             state_r;
  logic               enable_r, irq_en_r, ovf_r, sat_r, out_valid_r;
  logic [DATA_W-1:0]  coef_a_r, coef_b_r, coef_d_r, coef_e_r, coef_tx_r, coef_ty_r;
  logic [DATA_W-1:0]  fifo_x_r [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_y_r [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [PTR_W:0]     count_r;
  logic [DATA_W-1:0]  x_r, y_r, out_x_r, out_y_r;
  logic [1:0]         idx_r;
  logic               mul_start_r;
  logic [AW-1:0]      acc_x_r, acc_y_r;
  logic signed [RW-1:0] rnd_x_r, rnd_y_r;

  logic               wr_any_s, wr_word_s, rd_s, clear_s, status_wr_s, xy_rd_s;
  logic               push_s, push_ok_s, pop_s, full_s, empty_s, busy_s;
  logic [DATA_W-1:0]  mul_a_s, mul_b_s;
  logic [PW-1:0]      mul_res_s;
  logic               mul_done_s, mul_busy_s;
  logic [AW-1:0]      prod_ext_s;
  logic signed [RW-1:0] sum_x_s, sum_y_s, rnd_x_s, rnd_y_s;
  logic [DATA_W-1:0]  red_x_s, red_y_s;
  logic               clamp_s;
  logic [31:0]        status_s;
  logic               unused_s;

  assign wr_any_s    = (data_write_n != 2'b11);
  assign wr_word_s   = (data_write_n == 2'b10);
  assign rd_s        = (data_read_n != 2'b11);
  assign clear_s     = wr_any_s && (address == ADDR_CONTROL) && data_in[CTRL_CLEAR];
  assign status_wr_s = wr_any_s && (address == ADDR_STATUS);
  assign xy_rd_s     = rd_s && (address == ADDR_XY_OUT);
  assign full_s      = (count_r == DEPTH_CNT);
  assign empty_s     = (count_r == '0);
  assign push_s      = wr_word_s && (address == ADDR_XY_IN) && !clear_s;
  assign push_ok_s   = push_s && !full_s;
  assign pop_s       = (state_r == IDLE) && enable_r && !empty_s && !clear_s;
  assign busy_s      = (state_r != IDLE);
  assign prod_ext_s  = {{2{mul_res_s[PW-1]}}, mul_res_s};

  // Software-visible configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_r  <= 1'b0;
      irq_en_r  <= 1'b0;
      coef_a_r  <= '0;
      coef_b_r  <= '0;
      coef_d_r  <= '0;
      coef_e_r  <= '0;
      coef_tx_r <= '0;
      coef_ty_r <= '0;
    end else if (wr_any_s) begin
      case (address)
        ADDR_CONTROL: begin
          enable_r <= data_in[CTRL_ENABLE];
          irq_en_r <= data_in[CTRL_IRQ_EN];
        end
        ADDR_A:  coef_a_r  <= data_in[DATA_W-1:0];
        ADDR_B:  coef_b_r  <= data_in[DATA_W-1:0];
        ADDR_D:  coef_d_r  <= data_in[DATA_W-1:0];
        ADDR_E:  coef_e_r  <= data_in[DATA_W-1:0];
        ADDR_TX: coef_tx_r <= data_in[DATA_W-1:0];
        ADDR_TY: coef_ty_r <= data_in[DATA_W-1:0];
        default: ;
      endcase
    end
  end

  // Input point FIFO; a push while full is dropped and latches ovf.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_x_r[i] <= '0;
        fifo_y_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else if (clear_s) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovf_r    <= 1'b0;
    end else begin
      if (status_wr_s && data_in[ST_OVF]) ovf_r <= 1'b0;
      if (push_s && full_s) ovf_r <= 1'b1;
      if (push_ok_s) begin
        fifo_x_r[wr_ptr_r] <= data_in[DATA_W-1:0];
        fifo_y_r[wr_ptr_r] <= data_in[16+DATA_W-1:16];
        wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Operand selection for the product sequence a*x, b*y, d*x, e*y.
  always_comb begin
    mul_a_s = coef_a_r;
    mul_b_s = x_r;
    case (idx_r)
      2'd0:    begin mul_a_s = coef_a_r; mul_b_s = x_r; end
      2'd1:    begin mul_a_s = coef_b_r; mul_b_s = y_r; end
      2'd2:    begin mul_a_s = coef_d_r; mul_b_s = x_r; end
      2'd3:    begin mul_a_s = coef_e_r; mul_b_s = y_r; end
      default: begin mul_a_s = coef_a_r; mul_b_s = x_r; end
    endcase
  end

  affinex_seq_mul #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start_r),
    .a_i      (mul_a_s),
    .b_i      (mul_b_s),
    .result_o (mul_res_s),
    .done     (mul_done_s),
    .busy     (mul_busy_s)
  );

  // Round half up at the fraction boundary, then add the translation.
  always_comb begin
    sum_x_s = $signed({acc_x_r[AW-1], acc_x_r}) + $signed(HALF);
    sum_y_s = $signed({acc_y_r[AW-1], acc_y_r}) + $signed(HALF);
    rnd_x_s = (sum_x_s >>> FRAC_W) + $signed({{(RW-DATA_W){coef_tx_r[DATA_W-1]}}, coef_tx_r});
    rnd_y_s = (sum_y_s >>> FRAC_W) + $signed({{(RW-DATA_W){coef_ty_r[DATA_W-1]}}, coef_ty_r});
  end

  // Reduction to DATA_W bits: clamp when saturation is built in, otherwise wrap.
  always_comb begin
    red_x_s = rnd_x_r[DATA_W-1:0];
    red_y_s = rnd_y_r[DATA_W-1:0];
    clamp_s = 1'b0;
`ifdef AFFINEX_SAT_EN
    if (rnd_x_r > MAX_V) begin
      red_x_s = MAX_V[DATA_W-1:0];
      clamp_s = 1'b1;
    end else if (rnd_x_r < MIN_V) begin
      red_x_s = MIN_V[DATA_W-1:0];
      clamp_s = 1'b1;
    end else begin
      red_x_s = rnd_x_r[DATA_W-1:0];
    end
    if (rnd_y_r > MAX_V) begin
      red_y_s = MAX_V[DATA_W-1:0];
      clamp_s = 1'b1;
    end else if (rnd_y_r < MIN_V) begin
      red_y_s = MIN_V[DATA_W-1:0];
      clamp_s = 1'b1;
    end else begin
      red_y_s = rnd_y_r[DATA_W-1:0];
    end
`endif
  end

  // Point sequencer; a done pulse seen together with start is stale and ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      x_r         <= '0;
      y_r         <= '0;
      idx_r       <= 2'd0;
      mul_start_r <= 1'b0;
      acc_x_r     <= '0;
      acc_y_r     <= '0;
      rnd_x_r     <= '0;
      rnd_y_r     <= '0;
      out_x_r     <= '0;
      out_y_r     <= '0;
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
    end else if (clear_s) begin
      state_r     <= IDLE;
      idx_r       <= 2'd0;
      mul_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      sat_r       <= 1'b0;
    end else begin
      if (xy_rd_s) out_valid_r <= 1'b0;
      if (status_wr_s && data_in[ST_SAT]) sat_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            x_r     <= fifo_x_r[rd_ptr_r];
            y_r     <= fifo_y_r[rd_ptr_r];
            acc_x_r <= '0;
            acc_y_r <= '0;
            state_r <= LOAD;
          end
        end
        LOAD: begin
          idx_r       <= 2'd0;
          mul_start_r <= 1'b1;
          state_r     <= MUL;
        end
        MUL: begin
          mul_start_r <= 1'b0;
          if (mul_done_s && !mul_start_r) begin
            if (idx_r[1]) acc_y_r <= acc_y_r + prod_ext_s;
            else          acc_x_r <= acc_x_r + prod_ext_s;
            if (idx_r == 2'd3) begin
              state_r <= ROUND;
            end else begin
              idx_r       <= idx_r + 2'd1;
              mul_start_r <= 1'b1;
            end
          end
        end
        ROUND: begin
          rnd_x_r <= rnd_x_s;
          rnd_y_r <= rnd_y_s;
          state_r <= DONE;
        end
        DONE: begin
          if (!out_valid_r) begin
            out_x_r     <= red_x_s;
            out_y_r     <= red_y_s;
            out_valid_r <= 1'b1;
            if (clamp_s) sat_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Register read mux.
  always_comb begin
    status_s               = 32'h0000_0000;
    status_s[ST_OUT_VALID] = out_valid_r;
    status_s[ST_BUSY]      = busy_s;
    status_s[ST_FULL]      = full_s;
    status_s[ST_EMPTY]     = empty_s;
    status_s[ST_OVF]       = ovf_r;
    status_s[ST_SAT]       = sat_r;
    data_out = 32'h0000_0000;
    case (address)
      ADDR_CONTROL: data_out = {30'd0, irq_en_r, enable_r};
      ADDR_STATUS:  data_out = status_s;
      ADDR_A:       data_out = sext32(coef_a_r);
      ADDR_B:       data_out = sext32(coef_b_r);
      ADDR_D:       data_out = sext32(coef_d_r);
      ADDR_E:       data_out = sext32(coef_e_r);
      ADDR_TX:      data_out = sext32(coef_tx_r);
      ADDR_TY:      data_out = sext32(coef_ty_r);
      ADDR_XY_OUT:  data_out = {sext16(out_y_r), sext16(out_x_r)};
      default:      data_out = 32'h0000_0000;
    endcase
  end

  assign uo_out         = {busy_s, out_valid_r, full_s, empty_s, 4'b0000};
  assign data_ready     = 1'b1;
  assign user_interrupt = out_valid_r & irq_en_r;
  assign unused_s       = &{1'b0, ui_in, mul_busy_s, rnd_x_r[RW-1:DATA_W], rnd_y_r[RW-1:DATA_W]};

endmodule

// File: tb/tb_tqvp_affinex_pipe.sv
// Scoreboard bench for tqvp_affinex_pipe at default parameters; honours AFFINEX_SAT_EN.
module tb_tqvp_affinex_pipe;

  localparam int FW = 8;
  localparam logic [5:0] A_CTRL  = 6'h00;
  localparam logic [5:0] A_STAT  = 6'h04;
  localparam logic [5:0] A_COEF  = 6'h08;
  localparam logic [5:0] A_XYIN  = 6'h20;
  localparam logic [5:0] A_XYOUT = 6'h24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [7:0]  uo_out;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] sb_q[$];
  int          coef[6];

  tqvp_affinex_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .uo_out         (uo_out),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] wn);
    @(negedge clk);
    address      = addr;
    data_in      = data;
    data_write_n = wn;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [5:0] addr, output logic [31:0] data);
    @(negedge clk);
    address     = addr;
    data_read_n = 2'b00;
    #1 data = data_out;
    @(negedge clk);
    data_read_n = 2'b11;
  endtask

  task automatic set_coef(input int idx, input logic [15:0] v);
    bus_write(A_COEF + 6'(4 * idx), {16'h0000, v}, 2'b10);
    coef[idx] = int'($signed(v));
  endtask

  function automatic logic [15:0] reduce(input longint r);
`ifdef AFFINEX_SAT_EN
    if (r > 32767) return 16'h7FFF;
    if (r < -32768) return 16'h8000;
`endif
    return r[15:0];
  endfunction

  function automatic longint round_off(input longint acc, input int t);
    return ((acc + longint'(1 << (FW - 1))) >>> FW) + longint'(t);
  endfunction

  function automatic logic [31:0] model(input int x, input int y);
    longint ax, ay;
    ax = longint'(coef[0]) * x + longint'(coef[1]) * y;
    ay = longint'(coef[2]) * x + longint'(coef[3]) * y;
    return {reduce(round_off(ay, coef[5])), reduce(round_off(ax, coef[4]))};
  endfunction

  task automatic push_point(input int x, input int y, input bit track);
    bus_write(A_XYIN, {y[15:0], x[15:0]}, 2'b10);
    if (track) sb_q.push_back(model(x, y));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!uo_out[6] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!uo_out[6]) check_eq({tag, "_timeout"}, {31'd0, uo_out[6]}, 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!uo_out[7] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_busy"}, {31'd0, uo_out[7]}, 32'd1);
  endtask

  task automatic pop_check(input string tag, output logic [31:0] d);
    logic [31:0] exp;
    wait_valid(tag);
    bus_read(A_XYOUT, d);
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_eq(tag, d, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          lat;
    logic [15:0] sat_x;
    logic        sat_bit;
`ifdef AFFINEX_SAT_EN
    sat_x   = 16'h7FFF;
    sat_bit = 1'b1;
`else
    sat_x   = 16'hFF00;
    sat_bit = 1'b0;
`endif
    rst_n = 1'b0; ui_in = 8'h00; address = 6'h00; data_in = 32'h0;
    data_write_n = 2'b11; data_read_n = 2'b11;
    for (int i = 0; i < 6; i++) coef[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check_eq("rst_uo_out", {24'h0, uo_out}, 32'h10);
    check_eq("rst_data_out", data_out, 32'h0);
    check_eq("rst_irq", {31'd0, user_interrupt}, 32'd0);
    check_eq("rst_ready", {31'd0, data_ready}, 32'd1);

    // Identity transform with translation and exact latency.
    set_coef(0, 16'h0100); set_coef(1, 16'h0000); set_coef(2, 16'h0000);
    set_coef(3, 16'h0100); set_coef(4, 16'h0005); set_coef(5, 16'hFFFD);
    bus_read(6'h1C, d);
    check_eq("ty_sext", d, 32'hFFFF_FFFD);
    bus_write(A_CTRL, 32'h3, 2'b10);
    push_point(100, 200, 1'b1);
    wait_busy("ident");
    lat = 0;
    while (!uo_out[6] && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check_eq("latency", 32'(lat), 32'd71);
    check_eq("irq_rise", {31'd0, user_interrupt}, 32'd1);
    pop_check("ident_model", d);
    check_eq("ident_xy", d, 32'h00C5_0069);
    #1 check_eq("irq_drop", {31'd0, user_interrupt}, 32'd0);

    // Round half up.
    set_coef(0, 16'h0080); set_coef(3, 16'h0000); set_coef(4, 16'h0000); set_coef(5, 16'h0000);
    push_point(1, 0, 1'b1);
    pop_check("rnd_p1", d);
    check_eq("rnd_p1_x", {16'h0, d[15:0]}, 32'd1);
    push_point(-1, 0, 1'b1);
    pop_check("rnd_m1", d);
    check_eq("rnd_m1_x", {16'h0, d[15:0]}, 32'd0);
    set_coef(1, 16'h0080);
    push_point(3, 1, 1'b1);
    pop_check("rnd_3_1", d);
    check_eq("rnd_3_1_x", {16'h0, d[15:0]}, 32'd2);

    // Large product: clamp or wrap.
    set_coef(1, 16'h0000); set_coef(0, 16'h7FFF);
    push_point(32767, 0, 1'b1);
    pop_check("sat", d);
    check_eq("sat_x", {16'h0, d[15:0]}, {16'h0, sat_x});
    bus_read(A_STAT, d);
    check_eq("sat_flag", {31'd0, d[5]}, {31'd0, sat_bit});
    bus_write(A_STAT, 32'h20, 2'b10);
    bus_read(A_STAT, d);
    check_eq("sat_w1c", d, 32'h08);

    // Overflow with enable off, then drain with backpressure.
    bus_write(A_CTRL, 32'h2, 2'b10);
    set_coef(0, 16'h0100); set_coef(3, 16'h0100); set_coef(4, 16'h0001); set_coef(5, 16'hFFFF);
    for (int i = 0; i < 4; i++) push_point(10 * i + 3, -7 * i - 2, 1'b1);
    push_point(99, 99, 1'b0);
    #1;
    check_eq("ovf_full", {31'd0, uo_out[5]}, 32'd1);
    check_eq("ovf_empty", {31'd0, uo_out[4]}, 32'd0);
    bus_read(A_STAT, d);
    check_eq("ovf_flag", {31'd0, d[4]}, 32'd1);
    bus_write(A_CTRL, 32'h3, 2'b10);
    repeat (200) @(negedge clk);
    #1 check_eq("stall_busy_valid", {30'd0, uo_out[7:6]}, 32'd3);
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i), d);
    repeat (5) @(negedge clk);
    #1 check_eq("drain_idle", {24'h0, uo_out}, 32'h10);
    bus_write(A_STAT, 32'h10, 2'b10);
    bus_read(A_STAT, d);
    check_eq("ovf_w1c", d, 32'h08);

    // Clear in the middle of a multiply.
    push_point(7, 9, 1'b0);
    wait_busy("clr");
    repeat (10) @(negedge clk);
    bus_write(A_CTRL, 32'h7, 2'b10);
    #1 check_eq("clr_uo", {24'h0, uo_out}, 32'h10);
    bus_read(A_COEF, d);
    check_eq("clr_coef_a", d, 32'h0000_0100);
    bus_read(A_CTRL, d);
    check_eq("clr_ctrl", d, 32'h3);

    // Asynchronous reset in the middle of a multiply.
    push_point(11, 12, 1'b0);
    wait_busy("rst");
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_eq("arst_uo", {24'h0, uo_out}, 32'h10);
    check_eq("arst_irq", {31'd0, user_interrupt}, 32'd0);
    address = A_CTRL;
    #1 check_eq("arst_ctrl", data_out, 32'h0);
    address = A_COEF;
    #1 check_eq("arst_a", data_out, 32'h0);
    address = 6'h18;
    #1 check_eq("arst_tx", data_out, 32'h0);
    address = A_STAT;
    #1 check_eq("arst_stat", data_out, 32'h08);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
